// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// The top-level parameters default to these values.
package rf_wb_pkg;
  localparam int RF_NSRC       = 4;
  localparam int RF_WP         = 3;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_FIFO_DEPTH = 2;
  localparam int ROWS          = 2 ** RF_ADDR_WIDTH;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [RF_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef logic [$clog2(RF_WP+1)-1:0] gcnt_t;
  typedef logic [$clog2(RF_NSRC)-1:0] rr_ptr_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Single-source write-back FIFO. Slot 0 is always the head, and the
// per-slot valid/address view feeds the PENDING bitmap.
module rf_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [AW-1:0]                i_addr,
  input  logic [DW-1:0]                i_data,
  input  logic                         i_pop,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic [AW-1:0]                o_head_addr,
  output logic [DW-1:0]                o_head_data,
  output logic [DEPTH-1:0]             o_ent_vld,
  output logic [DEPTH*AW-1:0]          o_ent_addr
);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] r_count;
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_wr_idx;

  assign w_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_push   = i_push && !w_full && !i_flush;
  assign w_pop    = i_pop && !o_empty && !i_flush;
  assign w_wr_idx = w_pop ? (r_count - CW'(1)) : r_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Pop shifts toward slot 0; a simultaneous push lands in the slot vacated at the tail.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam int NXT = (i + 1 < DEPTH) ? i + 1 : i;
    always_ff @(posedge CLK) begin
      if (w_push && (CW'(i) == w_wr_idx)) begin
        r_addr[i] <= i_addr;
        r_data[i] <= i_data;
      end else if (w_pop) begin
        r_addr[i] <= r_addr[NXT];
        r_data[i] <= r_data[NXT];
      end
    end
    assign o_ent_vld[i]            = (CW'(i) < r_count);
    assign o_ent_addr[i*AW +: AW]  = r_addr[i];
  end

  assign o_count     = r_count;
  assign o_head_addr = r_addr[0];
  assign o_head_data = r_data[0];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: buffers producer results per source and grants up to
// WP row-distinct register-file writes per cycle in round-robin order.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int NSRC       = RF_NSRC,
  parameter int WP         = RF_WP,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int FIFO_DEPTH = RF_FIFO_DEPTH
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         FLUSH,
  input  logic [NSRC-1:0]              SRC_VALID,
  output logic [NSRC-1:0]              SRC_READY,
  input  logic [NSRC*ADDR_WIDTH-1:0]   SRC_ADDR,
  input  logic [NSRC*DATA_WIDTH-1:0]   SRC_DATA,
  output logic [WP-1:0]                WE,
  output logic [WP*ADDR_WIDTH-1:0]     WADDR,
  output logic [WP*DATA_WIDTH-1:0]     DIN,
  output logic [2**ADDR_WIDTH-1:0]     PENDING
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int D  = FIFO_DEPTH;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int GW = $clog2(WP+1);
  localparam int RW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]       w_ready;
  logic [NSRC-1:0]       w_push;
  logic [NSRC-1:0]       w_empty;
  logic [CW-1:0]         w_count [NSRC];
  logic [NSRC*AW-1:0]    w_head_addr;
  logic [NSRC*DW-1:0]    w_head_data;
  logic [NSRC*D-1:0]     w_ent_vld;
  logic [NSRC*D*AW-1:0]  w_ent_addr;
  logic [NSRC-1:0]       w_grant;
  logic [GW-1:0]         w_ngrant;
  logic [RW-1:0]         w_last;
  logic [WP*AW-1:0]      w_gaddr;
  logic [WP*DW-1:0]      w_gdata;
  logic [2**AW-1:0]      w_pending;

  logic [WP-1:0]         r_we;
  logic [WP*AW-1:0]      r_waddr;
  logic [WP*DW-1:0]      r_din;
  logic [RW-1:0]         r_rr;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    assign w_ready[s] = RST_N && !FLUSH && (w_count[s] < CW'(FIFO_DEPTH));
    // Writes to x0 are acknowledged and discarded here.
    assign w_push[s]  = SRC_VALID[s] && w_ready[s] && (SRC_ADDR[s*AW +: AW] != '0);

    rf_wb_fifo #(.DEPTH(D), .AW(AW), .DW(DW)) u_fifo (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .i_flush     (FLUSH),
      .i_push      (w_push[s]),
      .i_addr      (SRC_ADDR[s*AW +: AW]),
      .i_data      (SRC_DATA[s*DW +: DW]),
      .i_pop       (w_grant[s]),
      .o_count     (w_count[s]),
      .o_empty     (w_empty[s]),
      .o_head_addr (w_head_addr[s*AW +: AW]),
      .o_head_data (w_head_data[s*DW +: DW]),
      .o_ent_vld   (w_ent_vld[s*D +: D]),
      .o_ent_addr  (w_ent_addr[s*D*AW +: D*AW])
    );
  end

  // Rotating scan; a head is skipped if its row is already granted this cycle.
  always_comb begin
    w_grant  = '0;
    w_ngrant = '0;
    w_last   = '0;
    w_gaddr  = '0;
    w_gdata  = '0;
    for (int i = 0; i < NSRC; i++) begin
      int   s;
      logic hit;
      s   = (int'(r_rr) + i) % NSRC;
      hit = 1'b0;
      for (int k = 0; k < WP; k++) begin
        if ((GW'(k) < w_ngrant) && (w_gaddr[k*AW +: AW] == w_head_addr[s*AW +: AW])) hit = 1'b1;
      end
      if (!w_empty[s] && (int'(w_ngrant) < WP) && !hit) begin
        w_gaddr[int'(w_ngrant)*AW +: AW] = w_head_addr[s*AW +: AW];
        w_gdata[int'(w_ngrant)*DW +: DW] = w_head_data[s*DW +: DW];
        w_grant[s] = 1'b1;
        w_last     = RW'(s);
        w_ngrant   = w_ngrant + GW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_we    <= '0;
      r_waddr <= '0;
      r_din   <= '0;
      r_rr    <= '0;
    end else if (FLUSH) begin
      r_we <= '0;
      r_rr <= '0;
    end else begin
      for (int k = 0; k < WP; k++) begin
        r_we[k] <= (GW'(k) < w_ngrant);
        if (GW'(k) < w_ngrant) begin
          r_waddr[k*AW +: AW] <= w_gaddr[k*AW +: AW];
          r_din[k*DW +: DW]   <= w_gdata[k*DW +: DW];
        end
      end
      if (w_ngrant != '0) r_rr <= RW'((int'(w_last) + 1) % NSRC);
    end
  end

  always_comb begin
    w_pending = '0;
    for (int e = 0; e < NSRC*D; e++) begin
      if (w_ent_vld[e]) w_pending[w_ent_addr[e*AW +: AW]] = 1'b1;
    end
    for (int k = 0; k < WP; k++) begin
      if (r_we[k]) w_pending[r_waddr[k*AW +: AW]] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

  assign SRC_READY = w_ready;
  assign WE        = r_we;
  assign WADDR     = r_waddr;
  assign DIN       = r_din;
  assign PENDING   = w_pending;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int NSRC = 4, WP = 3, AW = 5, DW = 32, DEPTH = 2;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b1;
  logic                 FLUSH = 1'b0;
  logic [NSRC-1:0]      SRC_VALID = '0;
  logic [NSRC-1:0]      SRC_READY;
  logic [NSRC*AW-1:0]   SRC_ADDR = '0;
  logic [NSRC*DW-1:0]   SRC_DATA = '0;
  logic [WP-1:0]        WE;
  logic [WP*AW-1:0]     WADDR;
  logic [WP*DW-1:0]     DIN;
  logic [31:0]          PENDING;

  rf_wb_arbiter #(.NSRC(NSRC), .WP(WP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .SRC_VALID(SRC_VALID), .SRC_READY(SRC_READY),
    .SRC_ADDR(SRC_ADDR), .SRC_DATA(SRC_DATA), .WE(WE), .WADDR(WADDR), .DIN(DIN), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  wb_entry_t        q [NSRC][$];
  logic [WP-1:0]    m_we;
  logic [WP*AW-1:0] m_waddr;
  logic [WP*DW-1:0] m_din;
  int               m_rr;
  logic [DW-1:0]    dut_rf [32];
  logic [DW-1:0]    mod_rf [32];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSRC; s++) q[s].delete();
    m_we = '0; m_waddr = '0; m_din = '0; m_rr = 0;
  endtask

  task automatic drive(input logic [NSRC-1:0] v, input logic [NSRC*AW-1:0] a,
                       input logic [NSRC*DW-1:0] d, input logic f);
    SRC_VALID = v; SRC_ADDR = a; SRC_DATA = d; FLUSH = f;
  endtask

  // Compare DUT against the model for the current cycle, then advance the model over the edge.
  task automatic check_and_step();
    logic [NSRC-1:0] er;
    logic [31:0]     ep;
    logic [AW-1:0]   ga [$];
    logic [WP-1:0]   nwe;
    int              last;
    for (int s = 0; s < NSRC; s++) er[s] = (q[s].size() < DEPTH) && !FLUSH;
    ep = '0;
    for (int s = 0; s < NSRC; s++)
      for (int e = 0; e < q[s].size(); e++) ep[q[s][e].addr] = 1'b1;
    for (int k = 0; k < WP; k++) if (m_we[k]) ep[m_waddr[k*AW +: AW]] = 1'b1;
    ep[0] = 1'b0;
    chk("ready", SRC_READY, er);
    chk("we", WE, m_we);
    chk("waddr", WADDR, m_waddr);
    chk("din", DIN, m_din);
    chk("pending", PENDING, ep);
    for (int k = 0; k < WP; k++) begin
      if (WE[k]) dut_rf[WADDR[k*AW +: AW]] = DIN[k*DW +: DW];
      if (m_we[k]) mod_rf[m_waddr[k*AW +: AW]] = m_din[k*DW +: DW];
    end
    if (FLUSH) begin
      for (int s = 0; s < NSRC; s++) q[s].delete();
      m_we = '0; m_rr = 0;
    end else begin
      nwe = '0; last = -1;
      for (int i = 0; i < NSRC; i++) begin
        int s; bit taken;
        s = (m_rr + i) % NSRC;
        taken = 0;
        if (q[s].size() > 0) foreach (ga[j]) if (ga[j] == q[s][0].addr) taken = 1;
        if (q[s].size() > 0 && ga.size() < WP && !taken) begin
          nwe[ga.size()] = 1'b1;
          m_waddr[ga.size()*AW +: AW] = q[s][0].addr;
          m_din[ga.size()*DW +: DW]   = q[s][0].data;
          ga.push_back(q[s][0].addr);
          void'(q[s].pop_front());
          last = s;
        end
      end
      m_we = nwe;
      if (last >= 0) m_rr = (last + 1) % NSRC;
      for (int s = 0; s < NSRC; s++)
        if (SRC_VALID[s] && er[s] && SRC_ADDR[s*AW +: AW] != '0)
          q[s].push_back('{addr: SRC_ADDR[s*AW +: AW], data: SRC_DATA[s*DW +: DW]});
    end
  endtask

  task automatic tick();
    #2;
    check_and_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    drive('0, '0, '0, 1'b0);
    #1;
    chk("rst_we", WE, 0);
    chk("rst_waddr", WADDR, 0);
    chk("rst_din", DIN, 0);
    chk("rst_pending", PENDING, 0);
    chk("rst_ready", SRC_READY, 0);
    model_reset();
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin dut_rf[r] = '0; mod_rf[r] = '0; end
    #1;
    do_reset();
    @(posedge CLK); #1;

    // Single write: WE two cycles after the handshake, PENDING spans t+1..t+2.
    drive(4'b0001, {15'd0, 5'd5}, {96'd0, 32'hDEADBEEF}, 1'b0);
    tick();
    drive('0, '0, '0, 1'b0);
    chk("single_pend_t1", PENDING[5], 1'b1);
    chk("single_we_t1", WE, 0);
    tick();
    chk("single_we_t2", WE, 3'b001);
    chk("single_waddr_t2", WADDR[4:0], 5'd5);
    chk("single_din_t2", DIN[31:0], 32'hDEADBEEF);
    chk("single_pend_t2", PENDING[5], 1'b1);
    tick();
    chk("single_pend_t3", PENDING, 0);

    // x0 drop.
    do_reset();
    drive(4'b0010, {10'd0, 5'd0, 5'd0}, {64'd0, 32'h1234, 32'd0}, 1'b0);
    #1;
    chk("x0_ready", SRC_READY[1], 1'b1);
    tick();
    drive('0, '0, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("x0_we", WE, 0);
      chk("x0_pending", PENDING, 0);
      tick();
    end

    // Over-subscription: four distinct rows, three ports.
    do_reset();
    drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hD4, 32'hD3, 32'hD2, 32'hD1}, 1'b0);
    tick();
    drive('0, '0, '0, 1'b0);
    tick();
    chk("over_we1", WE, 3'b111);
    chk("over_waddr1", WADDR, {5'd3, 5'd2, 5'd1});
    chk("over_din1", DIN, {32'hD3, 32'hD2, 32'hD1});
    tick();
    chk("over_we2", WE, 3'b001);
    chk("over_waddr2", WADDR, {5'd3, 5'd2, 5'd4});
    chk("over_din2", DIN[31:0], 32'hD4);
    chk("over_rr_model", m_rr, 0);

    // Same-row conflict between src0 and src2.
    drive(4'b0101, {5'd0, 5'd7, 5'd0, 5'd7}, {32'd0, 32'h22, 32'd0, 32'h11}, 1'b0);
    tick();
    drive('0, '0, '0, 1'b0);
    tick();
    chk("conf_we1", WE, 3'b001);
    chk("conf_waddr1", WADDR[4:0], 5'd7);
    chk("conf_din1", DIN[31:0], 32'h11);
    tick();
    chk("conf_we2", WE, 3'b001);
    chk("conf_din2", DIN[31:0], 32'h22);
    tick();
    chk("conf_row7", dut_rf[7], 32'h22);
    chk("conf_row7_model", mod_rf[7], 32'h22);

    // Backpressure on src3 while sources 0-2 hold the ports.
    do_reset();
    drive(4'b1111, {5'd11, 5'd10, 5'd9, 5'd8}, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
    tick();
    chk("bp_ready3_t1", SRC_READY[3], 1'b1);
    tick();
    chk("bp_ready3_t2", SRC_READY[3], 1'b0);
    tick();
    chk("bp_ready3_t3", SRC_READY[3], 1'b1);
    for (int c = 0; c < 4; c++) tick();
    drive('0, '0, '0, 1'b0);
    for (int c = 0; c < 6; c++) tick();

    // FLUSH with six writes queued or in flight.
    do_reset();
    drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hF4, 32'hF3, 32'hF2, 32'hF1}, 1'b0);
    tick();
    drive(4'b0011, {10'd0, 5'd6, 5'd5}, {64'd0, 32'hF6, 32'hF5}, 1'b0);
    tick();
    drive(4'b1111, {5'd9, 5'd9, 5'd9, 5'd9}, {4{32'hAA}}, 1'b1);
    #1;
    chk("flush_ready", SRC_READY, 0);
    chk("flush_busy", PENDING != 0, 1'b1);
    tick();
    drive('0, '0, '0, 1'b0);
    chk("flush_we", WE, 0);
    chk("flush_pending", PENDING, 0);
    tick(); tick();

    // Reset pulse mid-stream.
    drive(4'b1111, {5'd15, 5'd14, 5'd13, 5'd12}, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b0);
    tick(); tick();
    do_reset();
    tick(); tick();

    // Randomized traffic with narrow address range to provoke conflicts.
    for (int c = 0; c < 3000; c++) begin
      logic [NSRC*AW-1:0] a;
      logic [NSRC*DW-1:0] d;
      if ($urandom_range(0, 499) == 0) do_reset();
      for (int s = 0; s < NSRC; s++) begin
        a[s*AW +: AW] = AW'($urandom_range(0, 7));
        d[s*DW +: DW] = $urandom;
      end
      drive(NSRC'($urandom), a, d, ($urandom_range(0, 49) == 0));
      tick();
    end
    drive('0, '0, '0, 1'b0);
    for (int c = 0; c < 6; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-back stage directly upstream of the multi-port register file (mpscm). It feeds the register file's WE/WADDR/DIN write ports.
- Collects results from NSRC producers (ALU, MUL/DIV, LSU, CSR) through valid/ready handshakes and buffers them in per-source FIFOs.
- Grants up to WP non-conflicting writes per cycle, round-robin, so the register file never sees two writes to one row in a cycle.
- Exports a PENDING bitmap of rows with queued writes, used by decode hazard logic.

Parameters:
- NSRC, 4, number of producer sources.
- WP, 3, register-file write ports; must equal the mpscm WP.
- ADDR_WIDTH, 5, register address width (ROWS = 2**ADDR_WIDTH).
- DATA_WIDTH, 32, register data width.
- FIFO_DEPTH, 2, entries per source FIFO; must be at least 1.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous clear of all queued and in-flight writes.
- SRC_VALID  in  NSRC  per-source result valid.
- SRC_READY  out  NSRC  per-source accept.
- SRC_ADDR  in  [ADDR_WIDTH-1:0] x NSRC  destination register.
- SRC_DATA  in  [DATA_WIDTH-1:0] x NSRC  result data.
- WE  out  WP  register-file write enables (registered).
- WADDR  out  [ADDR_WIDTH-1:0] x WP  write addresses (registered).
- DIN  out  [DATA_WIDTH-1:0] x WP  write data (registered).
- PENDING  out  2**ADDR_WIDTH  one bit per register row with a write queued or in flight.

Behaviour:
- Reset (RST_N low, async):
  - All FIFOs empty; rr_ptr=0.
  - WE=0, WADDR=0, DIN=0, PENDING=0.
  - SRC_READY forced 0 while RST_N is low.
- Accept:
  - SRC_READY[s] = (count[s] < FIFO_DEPTH) && !FLUSH. It depends only on registered state and FLUSH, never on the current cycle's grant.
  - A full FIFO does not accept even if it pops in the same cycle.
  - A handshake (VALID && READY) pushes {ADDR, DATA} at the closing edge.
- x0 drop: a handshake with SRC_ADDR==0 is accepted but not pushed. No WE results and PENDING is not affected.
- Candidates: the head of every non-empty FIFO; entries pushed this cycle are not candidates.
- Grant, combinational each cycle:
  - Scan sources starting at rr_ptr, wrapping modulo NSRC.
  - Grant a candidate if fewer than WP grants are made so far and its address differs from every address already granted this cycle.
  - A skipped candidate keeps its place and retries next cycle.
- Port mapping: the k-th grant in scan order drives port k. Ports k >= grant count get WE[k]=0; their WADDR/DIN hold previous values.
- Registered outputs: at the edge, granted entries pop and load WE/WADDR/DIN.
- Latency:
  - Handshake in cycle t; candidate in t+1; WE visible in t+2; row written at the end of t+2.
  - Sustained throughput is min(NSRC, WP) writes per cycle when addresses are distinct.
- Round-robin pointer:
  - rr_ptr <= (last granted source + 1) mod NSRC.
  - It is unchanged when there are no grants.
  - No source starves: a continuously non-empty source is granted within NSRC cycles unless it is blocked by address conflicts.
- Ordering:
  - Order within a source is preserved.
  - Cross-source ordering to the same register is not guaranteed. Upstream issue logic, using PENDING, must not create it.
- PENDING[r] is combinational, set if any of these holds:
  - Any valid FIFO entry has addr==r.
  - Some registered WE[k] is set with WADDR[k]==r.
  - PENDING[0] is always 0.
- FLUSH:
  - At the edge, all FIFOs are emptied, WE<=0 and rr_ptr<=0.
  - Handshakes in a FLUSH cycle are impossible because READY=0.
  - Writes already presented on WE in the FLUSH cycle still occur.
- Reset mid-operation: all queued writes are lost and outputs clear immediately.

Decomposition:
- Package rf_wb_pkg holds:
  - localparam ROWS.
  - typedef wb_entry_t {logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data;}.
  - Width typedefs for grant count and rr_ptr.
- Sub-module rf_wb_fifo: single-source FIFO with push, pop, full/empty, count, head and entries view (needed for PENDING). NSRC instances.

Test Plan:
- Reset then single write: src0 ADDR=5 DATA=0xDEADBEEF at t → WE[0]=1, WADDR[0]=5, DIN[0]=0xDEADBEEF at t+2; PENDING[5]=1 during t+1..t+2 and 0 at t+3.
- x0 drop: src1 ADDR=0 DATA=0x1234 → READY=1, no WE ever asserted, PENDING stays 0.
- Over-subscription: all 4 sources valid with distinct addrs 1..4, rr_ptr=0 → cycle 1 grants src0..2 on ports 0..2; next cycle grants src3 on port 0; rr_ptr ends at 0.
- Address conflict: src0 and src2 both ADDR=7 (0x11, 0x22) → only src0 written in the first cycle; src2 in the following cycle; final row 7 = 0x22.
- Backpressure: src3 valid every cycle with the arbiter blocked by sources 0-2 holding WP grants → READY[3] drops after 2 accepts (FIFO_DEPTH=2) and recovers once src3 is granted.
- FLUSH/reset mid-stream: queue 6 writes, assert FLUSH → WE=0 next cycle, PENDING=0, READY=0 in the FLUSH cycle; repeat with RST_N pulse → outputs clear asynchronously.
